// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default depth
// and requester port indices.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam int   DEPTH_DEFAULT = 16;
  localparam logic PORT_CPU      = 1'b0;
  localparam logic PORT_LDR      = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// a tie goes to the port named by rr_ptr_i.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       rr_ptr_i,
  output logic       grant_o,
  output logic       any_valid_o
);

  always_comb begin
    grant_o = PORT_CPU;
    if (&valid_i) begin
      grant_o = rr_ptr_i;
    end else if (valid_i[PORT_LDR]) begin
      grant_o = PORT_LDR;
    end
  end

  assign any_valid_o = |valid_i;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of single-port data_memory: accept, one strobe
// cycle, then a held response until the winning port consumes it.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [1:0]    req_we,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [31:0]   req_wdata0,
  input  logic [31:0]   req_wdata1,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_write_data,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [31:0]   mem_read_data
);

  state_t        state_q;
  logic          rr_ptr_q;
  logic          win_q;
  logic          we_q;
  logic          err_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;

  logic          grant;
  logic          any_valid;
  logic          in_access;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;

  rr_arb2 u_rr_arb2 (
    .valid_i     (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .any_valid_o (any_valid)
  );

  assign sel_addr  = (grant == PORT_LDR) ? req_addr1  : req_addr0;
  assign sel_wdata = (grant == PORT_LDR) ? req_wdata1 : req_wdata0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= PORT_CPU;
      win_q    <= PORT_CPU;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_valid) begin
            win_q   <= grant;
            we_q    <= req_we[grant];
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            err_q   <= (sel_addr >= AW'(DEPTH));
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          rdata_q <= (!we_q && !err_q) ? mem_read_data : 32'd0;
          state_q <= S_RESP;
        end
        S_RESP: begin
          // Pointer moves only on completion so a stalled response keeps priority order.
          if (rsp_ready[win_q]) begin
            rr_ptr_q <= ~win_q;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_access = (state_q == S_ACCESS);

  assign req_ready = (state_q == S_IDLE && any_valid && !rst)
                   ? ((grant == PORT_LDR) ? 2'b10 : 2'b01) : 2'b00;

  // Strobes are gated by rst directly so a reset landing in ACCESS kills the write.
  assign mem_write      = in_access & we_q & ~err_q & ~rst;
  assign mem_read       = in_access & ~we_q & ~err_q & ~rst;
  assign mem_addr       = in_access ? addr_q  : '0;
  assign mem_write_data = in_access ? wdata_q : 32'd0;

  assign rsp_valid = (state_q == S_RESP) ? ((win_q == PORT_LDR) ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = (state_q == S_RESP) && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked by a
// transaction-level reference model and a response scoreboard.
module tb_dmem_arbiter;

  localparam int DEPTH = 16;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_we = 2'b00;
  logic [AW-1:0] req_addr0 = '0;
  logic [AW-1:0] req_addr1 = '0;
  logic [31:0]   req_wdata0 = '0;
  logic [31:0]   req_wdata1 = '0;
  logic [1:0]    rsp_ready = 2'b11;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_write_data;
  logic          mem_write;
  logic          mem_read;
  logic [31:0]   mem_read_data;

  dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr0      (req_addr0),
    .req_addr1      (req_addr1),
    .req_wdata0     (req_wdata0),
    .req_wdata1     (req_wdata1),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp_v);
  endtask

  // data_memory stand-in: asynchronous read, write taken mid-cycle.
  logic [31:0] dmem [DEPTH];
  assign mem_read_data = dmem[mem_addr[3:0]];
  initial begin
    for (int i = 0; i < DEPTH; i++) dmem[i] = 32'(5 * (i + 1));
    forever begin
      @(negedge clk);
      if (mem_write && mem_addr < DEPTH) dmem[mem_addr[3:0]] = mem_write_data;
    end
  end

  // Reference model: one outstanding transaction, expected response fixed at accept.
  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          acc_cyc;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] model_mem [DEPTH];
  int          grant_log[$];
  int          acc_log[$];
  int          cyc = 0;
  bit          rr = 1'b0;
  bit          rst_prev = 1'b0;

  task automatic monitor_cycle();
    txn_t       t, n;
    bit         busy, acc_now, w;
    logic [1:0] exp_rdy;
    check("strobe_excl", mem_write & mem_read, 0);
    if (rst) begin
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_req_ready", req_ready, 0);
      if (rst_prev) begin
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_write_data, 0);
      end
      exp_q.delete();
      rr = 1'b0;
      rst_prev = 1'b1;
      return;
    end
    rst_prev = 1'b0;
    busy = (exp_q.size() != 0);
    if (busy) t = exp_q[0];
    acc_now = busy && (cyc == t.acc_cyc + 1);
    check("mem_write", mem_write, acc_now && t.we && !t.err);
    check("mem_read", mem_read, acc_now && !t.we && !t.err);
    if (acc_now) begin
      check("mem_addr", mem_addr, t.addr);
      if (t.we) check("mem_write_data", mem_write_data, t.wdata);
      if (t.we && !t.err) model_mem[t.addr[3:0]] = t.wdata;
    end else begin
      check("mem_addr_idle", mem_addr, 0);
      check("mem_wdata_idle", mem_write_data, 0);
    end
    if (busy && cyc >= t.acc_cyc + 2) begin
      check("rsp_valid", rsp_valid, t.port ? 2'b10 : 2'b01);
      check("rsp_rdata", rsp_rdata, t.rdata);
      check("rsp_err", rsp_err, t.err);
      if (rsp_ready[t.port]) begin
        void'(exp_q.pop_front());
        rr = ~t.port;
      end
    end else begin
      check("rsp_valid_idle", rsp_valid, 0);
    end
    exp_rdy = 2'b00;
    w = 1'b0;
    if (!busy && req_valid != 2'b00) begin
      w = (req_valid == 2'b11) ? rr : req_valid[1];
      exp_rdy[w] = 1'b1;
    end
    check("req_ready", req_ready, exp_rdy);
    if (exp_rdy != 2'b00) begin
      n.port    = w;
      n.we      = req_we[w];
      n.addr    = w ? req_addr1 : req_addr0;
      n.wdata   = w ? req_wdata1 : req_wdata0;
      n.err     = (n.addr >= DEPTH);
      n.rdata   = (!n.we && !n.err) ? model_mem[n.addr[3:0]] : 32'd0;
      n.acc_cyc = cyc;
      exp_q.push_back(n);
      grant_log.push_back(int'(w));
      acc_log.push_back(cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'(5 * (i + 1));
    forever begin
      @(negedge clk);
      cyc++;
      monitor_cycle();
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    step(n);
    rst = 1'b0;
  endtask

  task automatic set_req(input int p, input bit we, input logic [AW-1:0] a, input logic [31:0] d);
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    if (p == 0) begin
      req_addr0  = a;
      req_wdata0 = d;
    end else begin
      req_addr1  = a;
      req_wdata1 = d;
    end
  endtask

  task automatic issue(input int p, input bit we, input logic [AW-1:0] a, input logic [31:0] d);
    bit got = 1'b0;
    set_req(p, we, a, d);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = req_ready[p];
    end
    check("issue_accept", got, 1);
    @(posedge clk);
    #1;
    req_valid[p] = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r == 0) return 32'h8000_0000 | 32'($urandom_range(0, 15));
    if (r == 1) return 32'(DEPTH + $urandom_range(0, 3));
    return 32'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    int         idx;
    logic [1:0] taken;

    // Write then read back on port 0.
    do_reset(3);
    issue(0, 1'b1, 32'd3, 32'hDEAD_BEEF);
    step(3);
    issue(0, 1'b0, 32'd3, 32'd0);
    step(4);

    // Both ports hammer reads; grants must alternate every 3 cycles.
    do_reset(3);
    idx = grant_log.size();
    req_we = 2'b00;
    req_addr0 = 32'd1;
    req_addr1 = 32'd2;
    req_valid = 2'b11;
    step(12);
    req_valid = 2'b00;
    step(4);
    check("contention_count", grant_log.size() - idx, 4);
    if (grant_log.size() >= idx + 4) begin
      for (int k = 0; k < 4; k++) begin
        check("contention_order", grant_log[idx + k], k % 2);
        if (k > 0) check("contention_gap", acc_log[idx + k] - acc_log[idx + k - 1], 3);
      end
    end

    // Port 1 response stalled for 4 cycles while port 0 waits.
    do_reset(3);
    rsp_ready = 2'b01;
    fork
      issue(1, 1'b0, 32'd7, 32'd0);
      begin
        step(1);
        issue(0, 1'b0, 32'd8, 32'd0);
      end
    join_none
    step(6);
    rsp_ready = 2'b11;
    wait fork;
    step(4);
    check("bp_accept_gap", acc_log[acc_log.size() - 1] - acc_log[acc_log.size() - 2], 7);

    // Out-of-range write must not touch memory.
    issue(0, 1'b1, 32'd16, 32'hAAAA_5555);
    step(3);
    issue(0, 1'b0, 32'd0, 32'd0);
    step(3);
    check("oor_mem0", dmem[0], 32'd5);

    // Reset lands on the ACCESS cycle of a write.
    issue(0, 1'b1, 32'd4, 32'h1234);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    check("rst_access_mem4", dmem[4], 32'd25);
    issue(0, 1'b0, 32'd4, 32'd0);
    step(4);

    // Random traffic on both ports with random response backpressure.
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      taken = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (taken[p] || !req_valid[p]) begin
          if ($urandom_range(0, 2) != 0) set_req(p, 1'($urandom), rand_addr(), $urandom);
          else req_valid[p] = 1'b0;
        end
      end
      rsp_ready = 2'($urandom);
    end

    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step(6);
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
